// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display driver: FSM states,
// BCD scratch sizing and active-high gfedcba glyphs for the digits 0-9.
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // ceil(value_w * log10(2)) in integer arithmetic (log10(2) ~= 0.30103)
    function automatic int full_digits(input int value_w);
        return (value_w * 30103 + 99999) / 100000;
    endfunction

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;

    localparam logic [9:0][6:0] GLYPHS = {GLYPH_9, GLYPH_8, GLYPH_7, GLYPH_6, GLYPH_5,
                                          GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0};

endpackage

// File: rtl/seg7_decoder.sv
// One BCD digit to gfedcba segments (bit0 = a). Blank or a non-decimal code
// turns every segment off; ACTIVE_LOW selects the drive polarity.
module seg7_decoder
    import score_display_pkg::*;
#(
    parameter int ACTIVE_LOW = 1
) (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] lit;

    always_comb begin
        lit = 7'h00;
        if (!blank && (bcd <= 4'd9)) begin
            lit = GLYPHS[bcd];
        end
        seg = (ACTIVE_LOW != 0) ? ~lit : lit;
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Samples value_in every REFRESH_CYCLES, converts it to BCD one bit per cycle
// (double dabble) and drives saturated BCD plus seven-segment digits.
// Define SCORE_DISPLAY_BLANK_EN to enable leading-zero blanking.
module score_display_ctrl
    import score_display_pkg::*;
#(
    parameter int VALUE_W        = 32,
    parameter int DIGITS         = 3,
    parameter int REFRESH_CYCLES = 1024,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    value_in,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic                  overflow,
    output logic                  busy,
    output logic                  update_pulse,
    output logic [1:0]            fsm_state
);

    localparam int FULL_DIGITS = full_digits(VALUE_W);
    // Pad the scratch so the low DIGITS nibbles always exist, even for narrow inputs
    localparam int SCR_DIGITS  = (FULL_DIGITS > DIGITS) ? FULL_DIGITS : DIGITS;
    localparam int SCR_W       = 4 * SCR_DIGITS;
    localparam int CNT_W       = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int BIT_W       = $clog2(VALUE_W + 1);

    logic [CNT_W-1:0]   refresh_cnt;
    logic               tick;
    state_t             state, next_state;
    logic               capture_en, shift_en, commit_en;
    logic [BIT_W-1:0]   bit_cnt;
    logic [VALUE_W-1:0] shift_reg;
    logic [SCR_W-1:0]   scratch, scratch_adj;
    logic               high_nonzero;
    logic [DIGITS-1:0]  blank;

    // Free-running sample timer, independent of the FSM and hold
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    assign tick = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ticks outside IDLE are simply not looked at, so they are dropped
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tick && !hold) next_state = CONV;
            CONV:    if (bit_cnt == BIT_W'(1)) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        capture_en = (state == IDLE) && tick && !hold;
        shift_en   = (state == CONV);
        commit_en  = (state == COMMIT);
        busy       = (state != IDLE);
        fsm_state  = state;
    end

    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < SCR_DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        high_nonzero = 1'b0;
        for (int i = DIGITS; i < SCR_DIGITS; i++) begin
            high_nonzero = high_nonzero | (|scratch[4*i +: 4]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            scratch      <= '0;
            bcd_out      <= '0;
            overflow     <= 1'b0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            if (capture_en) begin
                shift_reg <= value_in;
                scratch   <= '0;
                bit_cnt   <= BIT_W'(VALUE_W);
            end else if (shift_en) begin
                scratch   <= (scratch_adj << 1) | SCR_W'(shift_reg[VALUE_W-1]);
                shift_reg <= shift_reg << 1;
                bit_cnt   <= bit_cnt - BIT_W'(1);
            end else if (commit_en) begin
                update_pulse <= 1'b1;
                overflow     <= high_nonzero;
                bcd_out      <= high_nonzero ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
            end
        end
    end

`ifdef SCORE_DISPLAY_BLANK_EN
    logic lead_zero;

    // A digit blanks only if it and every digit above it are zero; digit 0 always shows
    always_comb begin
        blank     = '0;
        lead_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead_zero = lead_zero && (bcd_out[4*i +: 4] == 4'd0);
            blank[i]  = lead_zero && !overflow;
        end
    end
`else
    assign blank = '0;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_decoder #(
            .ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_dec (
            .bcd  (bcd_out[4*g +: 4]),
            .blank(blank[g]),
            .seg  (seg_out[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed-sequence bench for score_display_ctrl with a decimal-arithmetic
// reference model; a second instance with a short refresh exercises dropped ticks.
module tb_score_display_ctrl;

    localparam int VALUE_W   = 32;
    localparam int DIGITS    = 3;
    localparam int REFRESH   = 40;
    localparam int REFRESH_B = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hold  = 1'b0;
    logic [31:0] value_in = '0;

    logic [11:0] bcd_out, bcd_b;
    logic [20:0] seg_out, seg_b;
    logic        overflow, ovf_b, busy, busy_b, update_pulse, pulse_b;
    logic [1:0]  fsm_state, state_b;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    score_display_ctrl #(
        .VALUE_W(VALUE_W), .DIGITS(DIGITS), .REFRESH_CYCLES(REFRESH), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clock(clock), .reset(reset), .value_in(value_in), .hold(hold),
        .bcd_out(bcd_out), .seg_out(seg_out), .overflow(overflow), .busy(busy),
        .update_pulse(update_pulse), .fsm_state(fsm_state)
    );

    score_display_ctrl #(
        .VALUE_W(VALUE_W), .DIGITS(DIGITS), .REFRESH_CYCLES(REFRESH_B), .SEG_ACTIVE_LOW(1)
    ) dut_b (
        .clock(clock), .reset(reset), .value_in(value_in), .hold(hold),
        .bcd_out(bcd_b), .seg_out(seg_b), .overflow(ovf_b), .busy(busy_b),
        .update_pulse(pulse_b), .fsm_state(state_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    function automatic int digit_of(input logic [31:0] v, input int i);
        int div;
        div = (i == 0) ? 1 : (i == 1) ? 10 : 100;
        if (v >= 32'd1000) return 9;
        return int'((v / div) % 10);
    endfunction

    function automatic logic [11:0] model_bcd(input logic [31:0] v);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) r[4*i +: 4] = 4'(digit_of(v, i));
        return r;
    endfunction

    function automatic logic [20:0] model_seg(input logic [31:0] v);
        logic [20:0] s;
        bit          all_zero_above;
        all_zero_above = 1'b1;
        s = '0;
        for (int i = 2; i >= 0; i--) begin
            all_zero_above = all_zero_above && (digit_of(v, i) == 0);
`ifdef SCORE_DISPLAY_BLANK_EN
            if (i > 0 && all_zero_above && v < 32'd1000) s[7*i +: 7] = 7'h00;
            else s[7*i +: 7] = glyph_of(digit_of(v, i));
`else
            s[7*i +: 7] = glyph_of(digit_of(v, i));
`endif
        end
        return ~s;
    endfunction

    task automatic check_display(input string tag, input logic [31:0] v);
        check({tag, "_bcd"}, bcd_out, model_bcd(v));
        check({tag, "_ovf"}, overflow, v >= 32'd1000);
        check({tag, "_seg"}, seg_out, model_seg(v));
    endtask

    // Applies v, waits for capture, optionally changes value_in mid-conversion,
    // then checks latency, busy span, the committed result and pulse width.
    task automatic run_conv(input string tag, input logic [31:0] v, input bit change,
                            input logic [31:0] late_v, output int wait_cycles);
        int n, lat, busy_cnt;
        value_in = v;
        n = 0;
        while (!busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        wait_cycles = n;
        if (!busy) begin
            check({tag, "_capture_timeout"}, 0, 1);
            return;
        end
        lat = 0;
        busy_cnt = 1;
        while (!update_pulse && lat < 100) begin
            @(negedge clock);
            lat++;
            if (busy) busy_cnt++;
            if (change && lat == 3) value_in = late_v;
        end
        check({tag, "_latency"}, lat, VALUE_W + 1);
        check({tag, "_busy_span"}, busy_cnt, VALUE_W + 1);
        check_display(tag, v);
        @(negedge clock);
        check({tag, "_pulse_width"}, update_pulse, 0);
    endtask

    initial begin
        int          w, pulses, busy_seen, gap, n;
        logic [31:0] r;

        // Reset state
        repeat (3) @(negedge clock);
        check_display("reset", 0);
        check("reset_busy", busy, 0);
        check("reset_pulse", update_pulse, 0);
        check("reset_state", fsm_state, 0);
        check("reset_seg_const", seg_out, model_seg(0));
        reset = 1'b0;

        // First tick lands REFRESH edges after release
        run_conv("v123", 32'd123, 1'b0, 0, w);
        check("first_tick", w, REFRESH);

        run_conv("v1000", 32'd1000, 1'b0, 0, w);
        run_conv("v999", 32'd999, 1'b0, 0, w);
        run_conv("v7", 32'd7, 1'b0, 0, w);
        run_conv("v0", 32'd0, 1'b0, 0, w);
        run_conv("v_max", 32'hFFFF_FFFF, 1'b0, 0, w);

        // Late change of value_in must not leak into the running conversion
        run_conv("v45", 32'd45, 1'b1, 32'd67, w);
        run_conv("v67", 32'd67, 1'b0, 0, w);

        // hold across two ticks: nothing captured, display frozen
        hold = 1'b1;
        value_in = 32'd321;
        pulses = 0;
        busy_seen = 0;
        repeat (2 * REFRESH + 10) begin
            @(negedge clock);
            if (update_pulse) pulses++;
            if (busy) busy_seen++;
        end
        check("hold_pulses", pulses, 0);
        check("hold_busy", busy_seen, 0);
        check_display("hold", 32'd67);
        hold = 1'b0;
        run_conv("after_hold", 32'd321, 1'b0, 0, w);

        // Reset 10 cycles into a conversion: outputs clear at once, no commit
        value_in = 32'd555;
        n = 0;
        while (!busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("pre_reset_busy", busy, 1);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check_display("midreset", 0);
        check("midreset_busy", busy, 0);
        check("midreset_pulse", update_pulse, 0);
        pulses = 0;
        repeat (3) begin
            @(negedge clock);
            if (update_pulse) pulses++;
        end
        check("midreset_no_pulse", pulses, 0);
        reset = 1'b0;
        run_conv("v555", 32'd555, 1'b0, 0, w);
        check("restart_tick", w, REFRESH);

        // Random values against the decimal model
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) r = 32'($urandom_range(0, 1200));
            else r = $urandom;
            run_conv("rand", r, 1'b0, 0, w);
        end

        // Short-refresh instance: a tick inside a conversion is dropped
        value_in = 32'd777;
        n = 0;
        while (busy_b && n < 100) begin
            @(negedge clock);
            n++;
        end
        while (!busy_b && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("drop_capture_seen", busy_b, 1);
        gap = 0;
        pulses = 0;
        while (busy_b && gap < 200) begin
            @(negedge clock);
            gap++;
            if (pulse_b) pulses++;
        end
        while (!busy_b && gap < 200) begin
            @(negedge clock);
            gap++;
            if (pulse_b) pulses++;
        end
        check("drop_gap", gap, 2 * REFRESH_B);
        check("drop_pulses", pulses, 1);
        check("drop_bcd", bcd_b, model_bcd(32'd777));
        check("drop_ovf", ovf_b, 0);
        check("drop_seg", seg_b, model_seg(32'd777));
        check("drop_state_busy", state_b != 2'd0, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/score_display_ctrl.md
# score_display_ctrl

Parametrised score-display driver between the processor's score register and the board's seven-segment digits. It periodically samples an unsigned binary value and converts it to BCD with a sequential double-dabble engine, one bit per cycle. It saturates when the value exceeds the digit count, then drives registered BCD and decoded seven-segment outputs for any number of digits. It replaces the fixed three-digit, fixed-interval combinational score path.

## Interface
Parameters:
- VALUE_W, 32, width of the binary input
- DIGITS, 3, number of displayed decimal digits (1..10)
- REFRESH_CYCLES, 1024, sample interval in clock cycles (>= 2)
- SEG_ACTIVE_LOW, 1, 1 = segment lit by driving 0

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- value_in  in  VALUE_W  unsigned score to display
- hold  in  1  freeze display; refresh ticks ignored while high
- bcd_out  out  4*DIGITS  committed BCD, digit 0 in [3:0]
- seg_out  out  7*DIGITS  segments per digit, bit order gfedcba (bit0 = a), digit 0 in [6:0]
- overflow  out  1  last committed value was >= 10^DIGITS
- busy  out  1  conversion in progress
- update_pulse  out  1  one-cycle strobe when bcd_out/overflow change

## Operation
- Refresh counter runs 0..REFRESH_CYCLES-1 and wraps. It runs continuously, independent of FSM state and hold.
- The tick is the cycle where the counter equals REFRESH_CYCLES-1.
- FSM states:
  - IDLE: on tick with hold=0, capture value_in into the shift register, clear the BCD scratch, load bit count = VALUE_W, and go to CONV.
  - CONV: add 3 to every scratch nibble >= 5, then shift left one bit from the shift register MSB. Decrement the bit count; at 0, go to COMMIT.
  - COMMIT: write bcd_out and overflow, pulse update_pulse, return to IDLE.
- Scratch holds FULL_DIGITS = ceil(VALUE_W*log10 2) nibbles (10 for 32 bits).
- Overflow: if any scratch nibble at index >= DIGITS is nonzero, bcd_out becomes all 9s and overflow = 1. Otherwise bcd_out is the low DIGITS nibbles and overflow = 0.
- A tick in CONV or COMMIT is dropped, not queued.
- Changes to value_in after capture do not affect the result.
- hold=1 on a tick: no capture. A conversion already running completes and commits normally.
- seg_out is combinationally decoded from bcd_out (0-9 standard glyphs), inverted when SEG_ACTIVE_LOW=1.
- When overflow=1, every digit shows 9.

## Timing
- Reset values: bcd_out = 0, overflow = 0, busy = 0, update_pulse = 0, counter = 0, FSM = IDLE. seg_out therefore shows "0" on every digit: 7'b1000000 per digit when active-low.
- Latency: capture at edge E. bcd_out, overflow and update_pulse are valid after edge E+VALUE_W+1 (33 cycles for VALUE_W=32).
- update_pulse is high for exactly one cycle.
- busy is high from edge E through edge E+VALUE_W+1 exclusive, i.e. in CONV and COMMIT.
- If REFRESH_CYCLES < VALUE_W+2, every other tick (or more) is dropped. This is legal.
- Reset asserted mid-conversion: all outputs return to reset values immediately. Counter and FSM restart, and no commit occurs.

## Configuration
- SCORE_DISPLAY_BLANK_EN defined: leading-zero blanking is enabled.
  - Any digit above digit 0 whose value and all higher digits' values are 0 drives all segments off (7'b1111111 active-low).
  - Digit 0 is never blanked.
  - Blanking is inactive when overflow=1.
- SCORE_DISPLAY_BLANK_EN undefined: all digits are always lit, including leading zeros.
- bcd_out is identical in both builds.

## Structure
- Shared package score_display_pkg holds:
  - FSM state typedef (IDLE, CONV, COMMIT)
  - function computing FULL_DIGITS from VALUE_W
  - 7-bit active-high glyph constants for 0-9
- One sub-module, seg7_decoder: a 4-bit BCD to 7-bit gfedcba decoder with a blank input. It is instantiated DIGITS times in a generate loop.
- The top level holds the counter, FSM, double-dabble datapath and blanking logic.

## Test plan
All scenarios use VALUE_W=32, DIGITS=3, REFRESH_CYCLES=40, SEG_ACTIVE_LOW=1.
- Reset -> bcd_out=12'h000, overflow=0, busy=0, seg_out=21'b1000000_1000000_1000000.
- value_in=123, tick -> update_pulse exactly 33 cycles after capture, bcd_out=12'h123, overflow=0.
  - With SCORE_DISPLAY_BLANK_EN and value_in=7: digits 2 and 1 read 1111111, digit 0 reads 1111000.
- value_in=1000 -> bcd_out=12'h999, overflow=1. Then value_in=999 -> bcd_out=12'h999, overflow=0.
- value_in=45 captured, changed to 67 during CONV -> commit 12'h045. Next tick commits 12'h067. Tick with REFRESH_CYCLES=20 during busy -> dropped, one pulse only.
- hold=1 across two ticks -> no update_pulse, bcd_out unchanged. Release -> next tick converts.
- reset pulsed 10 cycles into CONV of 555 -> outputs return to reset values at once, no update_pulse. Next tick after release converts normally.
